// File: rtl/bit_count_arbiter.sv
// -----------------------------------------------------------------------------
// bit_count_arbiter
//
// Round-robin front end for a single asserted-bit-count engine. Up to NUM_REQ
// client blocks offer jobs over per-requester valid/ready. One job at a time is
// accepted, handed to the engine with a one-cycle go pulse, and its result is
// returned over a single valid/ready response channel, tagged with the index
// of the requester that owns it.
//
// Optional build macro:
//   BIT_COUNT_ARBITER_TIMEOUT_EN - abort a job that waits more than
//   TIMEOUT_CYCLES cycles for eng_done; the response carries resp_err=1 and
//   resp_count=0. When undefined, the arbiter waits for eng_done forever and
//   resp_err is tied low.
//
// Ports:
//   clk, rst    rising-edge clock, asynchronous active-high reset
//   req_valid   per-requester job valid
//   req_data    packed job data, requester i at [i*WIDTH +: WIDTH]
//   req_ready   per-requester accept, one-hot or zero (combinational)
//   resp_valid  result available
//   resp_ready  result consumed
//   resp_id     index of the requester that owns the result
//   resp_count  number of asserted bits in the job data
//   resp_err    result is a timeout abort
//   busy        high whenever a job is in flight
//   eng_go      engine start pulse
//   eng_in      engine operand
//   eng_out     engine result, valid while eng_done is high
//   eng_done    engine done level
// -----------------------------------------------------------------------------
module bit_count_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int WIDTH          = 8,
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]      req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic [$clog2(NUM_REQ)-1:0]    resp_id,
  output logic [$clog2(WIDTH+1)-1:0]    resp_count,
  output logic                          resp_err,
  output logic                          busy,
  output logic                          eng_go,
  output logic [WIDTH-1:0]              eng_in,
  input  logic [$clog2(WIDTH+1)-1:0]    eng_out,
  input  logic                          eng_done
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(WIDTH+1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] ISSUE     = 3'd1;
  localparam logic [2:0] ARM       = 3'd2;
  localparam logic [2:0] WAIT_DONE = 3'd3;
  localparam logic [2:0] RESP      = 3'd4;

  if (NUM_REQ < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("bit_count_arbiter: NUM_REQ must be >= 2 and TIMEOUT_CYCLES >= 1");
  end

  logic [2:0]       state;
  logic [ID_W-1:0]  rr_ptr;
  logic [WIDTH-1:0] cap_data;
  logic [ID_W-1:0]  cap_id;

  logic             grant_found;
  logic [ID_W-1:0]  grant_idx;
  logic [ID_W-1:0]  next_ptr;
  logic [WIDTH-1:0] grant_data;

`ifdef BIT_COUNT_ARBITER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES+1);
  logic [TO_W-1:0] wait_cnt;
  logic            resp_err_q;
  assign resp_err = resp_err_q;
`else
  assign resp_err = 1'b0;
`endif

  // Round-robin search: first asserted req_valid at or above rr_ptr, wrapping.
  // NOTE: every signal written here gets a default before the loop, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    int cand;
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (int'(rr_ptr) + k) % NUM_REQ;
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(cand);
      end
    end
  end

  assign next_ptr   = (grant_idx == ID_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
  assign grant_data = req_data[int'(grant_idx)*WIDTH +: WIDTH];

  // The only combinational output. Gated by rst so every output reads zero
  // while reset is held, even with requests pending.
  always_comb begin
    req_ready = '0;
    if (!rst && state == IDLE && grant_found) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  // The operand comes straight from the capture register, so it is already
  // stable in the go cycle and stays put until the next accept.
  assign eng_in  = cap_data;
  assign resp_id = cap_id;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      cap_data   <= '0;
      cap_id     <= '0;
      resp_count <= '0;
      resp_valid <= 1'b0;
      busy       <= 1'b0;
      eng_go     <= 1'b0;
`ifdef BIT_COUNT_ARBITER_TIMEOUT_EN
      wait_cnt   <= '0;
      resp_err_q <= 1'b0;
`endif
    end else begin
      eng_go <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_found) begin
            cap_data <= grant_data;
            cap_id   <= grant_idx;
            rr_ptr   <= next_ptr;
            eng_go   <= 1'b1;
            busy     <= 1'b1;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          state <= ARM;
        end
        ARM: begin
          // eng_done may still be high from the previous job; skip one cycle
          // so the engine has dropped it before we start listening.
`ifdef BIT_COUNT_ARBITER_TIMEOUT_EN
          wait_cnt <= '0;
`endif
          state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (eng_done) begin
            resp_count <= eng_out;
            resp_valid <= 1'b1;
`ifdef BIT_COUNT_ARBITER_TIMEOUT_EN
            resp_err_q <= 1'b0;
`endif
            state      <= RESP;
          end
`ifdef BIT_COUNT_ARBITER_TIMEOUT_EN
          else if (wait_cnt == TO_W'(TIMEOUT_CYCLES-1)) begin
            resp_count <= '0;
            resp_err_q <= 1'b1;
            resp_valid <= 1'b1;
            state      <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          resp_valid <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bit_count_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bit_count_arbiter
//
// Drives bit_count_arbiter with directed scenarios followed by randomized
// traffic, against a transaction-level model of the arbiter and a behavioural
// bit-count engine with random latency. The model decides grants from the
// round-robin rule, remembers the accepted job, and predicts the go pulse,
// response timing and response contents.
// -----------------------------------------------------------------------------
module tb_bit_count_arbiter;

  localparam int NUM_REQ        = 4;
  localparam int WIDTH          = 8;
  localparam int TIMEOUT_CYCLES = 32;
  localparam int ID_W           = $clog2(NUM_REQ);
  localparam int CNT_W          = $clog2(WIDTH+1);

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     resp_valid;
  logic                     resp_ready;
  logic [ID_W-1:0]          resp_id;
  logic [CNT_W-1:0]         resp_count;
  logic                     resp_err;
  logic                     busy;
  logic                     eng_go;
  logic [WIDTH-1:0]         eng_in;
  logic [CNT_W-1:0]         eng_out;
  logic                     eng_done;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bit_count_arbiter #(
    .NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_count(resp_count), .resp_err(resp_err), .busy(busy),
    .eng_go(eng_go), .eng_in(eng_in), .eng_out(eng_out), .eng_done(eng_done)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural engine ----------------
  int   eng_lat_max = 4;
  bit   eng_stall   = 1'b0;
  logic eng_run;
  int   eng_wait;
  logic [CNT_W-1:0] eng_res;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      eng_done <= 1'b0; eng_out <= '0; eng_run <= 1'b0; eng_wait <= 0; eng_res <= '0;
    end else if (eng_go) begin
      eng_done <= 1'b0;
      eng_run  <= 1'b1;
      eng_wait <= int'($urandom_range(eng_lat_max, 0));
      eng_res  <= CNT_W'($countones(eng_in));
    end else if (eng_run && !eng_stall) begin
      if (eng_wait == 0) begin
        eng_done <= 1'b1;
        eng_out  <= eng_res;
        eng_run  <= 1'b0;
      end else begin
        eng_wait <= eng_wait - 1;
      end
    end
  end

  // ---------------- transaction-level model + compare ----------------
  typedef struct { int id; int count; bit err; } resp_t;
  resp_t log_q[$];

  bit               m_busy = 1'b0;
  int               m_ptr  = 0;
  int               m_acc  = 0;
  int               m_done = -1;
  int               m_id   = 0;
  bit               m_err  = 1'b0;
  logic [WIDTH-1:0] m_data = '0;

  logic [WIDTH-1:0] last_go_data = '0;
  int               go_cnt       = 0;
  int               last_go_cyc  = 0;
  int               first_valid_cyc = 0;
  bit               prev_valid   = 1'b0;

  always @(negedge clk) begin
    logic [NUM_REQ-1:0] exp_ready;
    int  g, c;
    bit  exp_go, exp_valid;
    if (rst) begin
      check("rst_req_ready", req_ready, 0);
      check("rst_resp_valid", resp_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_eng_go", eng_go, 0);
      check("rst_eng_in", eng_in, 0);
      check("rst_resp_id", resp_id, 0);
      check("rst_resp_count", resp_count, 0);
      check("rst_resp_err", resp_err, 0);
      m_busy = 1'b0; m_ptr = 0; m_done = -1; m_err = 1'b0; prev_valid = 1'b0;
    end else begin
      exp_ready = '0;
      g = -1;
      if (!m_busy) begin
        for (int k = 0; k < NUM_REQ; k++) begin
          c = (m_ptr + k) % NUM_REQ;
          if (g < 0 && req_valid[c]) g = c;
        end
      end
      if (g >= 0) exp_ready[g] = 1'b1;
      exp_go    = m_busy && (cyc == m_acc + 1);
      exp_valid = m_busy && (m_done >= 0) && (cyc > m_done);

      check("req_ready", req_ready, exp_ready);
      check("busy", busy, m_busy);
      check("eng_go", eng_go, exp_go);
      if (exp_go) check("eng_in", eng_in, m_data);
      check("resp_valid", resp_valid, exp_valid);
      if (exp_valid) begin
        check("resp_id", resp_id, m_id);
        check("resp_count", resp_count, m_err ? 0 : $countones(m_data));
        check("resp_err", resp_err, m_err);
      end

      if (eng_go) begin last_go_data = eng_in; go_cnt++; last_go_cyc = cyc; end
      if (resp_valid && !prev_valid) first_valid_cyc = cyc;
      prev_valid = resp_valid;

      if (g >= 0) begin
        m_busy = 1'b1; m_acc = cyc; m_id = g; m_done = -1; m_err = 1'b0;
        m_data = req_data[g*WIDTH +: WIDTH];
        m_ptr  = (g + 1) % NUM_REQ;
      end else if (m_busy && m_done < 0 && cyc >= m_acc + 3) begin
        // The job is listening for done from three cycles after the accept.
        if (eng_done) m_done = cyc;
`ifdef BIT_COUNT_ARBITER_TIMEOUT_EN
        else if (cyc == m_acc + 3 + TIMEOUT_CYCLES - 1) begin
          m_done = cyc; m_err = 1'b1;
        end
`endif
      end
      if (exp_valid && resp_ready) begin
        log_q.push_back('{id: m_id, count: (m_err ? 0 : $countones(m_data)), err: m_err});
        m_busy = 1'b0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic apply_reset();
    rst = 1'b1; tick(2); rst = 1'b0;
  endtask

  task automatic wait_log(input int n, input int budget);
    int t = 0;
    while (log_q.size() < n && t < budget) begin tick(); t++; end
    check("resp_wait_timeout", log_q.size() >= n, 1);
  endtask

  task automatic send_one(input int i, input logic [WIDTH-1:0] d);
    int t = 0;
    bit seen = 1'b0;
    req_valid = '0;
    req_valid[i] = 1'b1;
    req_data[i*WIDTH +: WIDTH] = d;
    while (!seen && t < 200) begin
      @(negedge clk);
      seen = req_ready[i];
      t++;
    end
    check("grant_wait_timeout", seen, 1);
    @(posedge clk); #1;
    req_valid = '0;
  endtask

  int go_before;

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req_valid = '0; req_data = '0; resp_ready = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(2);

    // Single job: popcount(B5) = 5.
    log_q.delete(); go_cnt = 0;
    send_one(0, 8'hB5);
    wait_log(1, 100);
    if (log_q.size() >= 1) begin
      check("single_id", log_q[0].id, 0);
      check("single_count", log_q[0].count, 5);
      check("single_err", log_q[0].err, 0);
    end
    check("single_go_pulses", go_cnt, 1);
    check("single_go_data", last_go_data, 8'hB5);

    // Contention from a fresh reset: 0101 held -> 0, 2, 0.
    apply_reset();
    log_q.delete();
    req_data  = {$urandom, $urandom};
    req_valid = 4'b0101;
    wait_log(3, 300);
    req_valid = '0;
    if (log_q.size() >= 3) begin
      check("contend_id0", log_q[0].id, 0);
      check("contend_id1", log_q[1].id, 2);
      check("contend_id2", log_q[2].id, 0);
    end

    // Pointer wrap: serving requester 3 returns the pointer to 0.
    log_q.delete();
    send_one(3, 8'hFF);
    wait_log(1, 100);
    if (log_q.size() >= 1) begin
      check("wrap_id3", log_q[0].id, 3);
      check("wrap_count", log_q[0].count, 8);
    end
    log_q.delete();
    req_valid = 4'b1001;
    wait_log(1, 100);
    req_valid = '0;
    if (log_q.size() >= 1) check("wrap_next_id", log_q[0].id, 0);

    // Backpressure: result held for 10 cycles, no new grant or go.
    tick(2);
    resp_ready = 1'b0;
    req_valid  = 4'b1111;
    begin
      int t = 0;
      while (!resp_valid && t < 100) begin tick(); t++; end
      check("bp_valid_seen", resp_valid, 1);
    end
    go_before = go_cnt;
    tick(10);
    check("bp_no_go", go_cnt - go_before, 0);
    check("bp_still_valid", resp_valid, 1);
    resp_ready = 1'b1;
    tick(6);
    req_valid = '0;
    check("bp_next_go", go_cnt - go_before, 1);
    tick(20);

    // Reset during WAIT_DONE with a slow engine.
    eng_lat_max = 30;
    send_one(2, 8'h3C);
    tick(2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    eng_lat_max = 4;
    log_q.delete();
    send_one(1, 8'h81);
    wait_log(1, 100);
    if (log_q.size() >= 1) begin
      check("post_rst_id", log_q[0].id, 1);
      check("post_rst_count", log_q[0].count, 2);
    end

`ifdef BIT_COUNT_ARBITER_TIMEOUT_EN
    // Engine never answers: abort 32 cycles after entering WAIT_DONE.
    tick(2);
    eng_stall = 1'b1;
    log_q.delete();
    send_one(0, 8'h0F);
    wait_log(1, 200);
    if (log_q.size() >= 1) begin
      check("to_err", log_q[0].err, 1);
      check("to_count", log_q[0].count, 0);
      check("to_id", log_q[0].id, 0);
    end
    check("to_latency", first_valid_cyc - (last_go_cyc + 2), TIMEOUT_CYCLES);
    eng_stall = 1'b0;
    apply_reset();
`endif

    // Randomized traffic; the compare process checks every cycle.
    for (int n = 0; n < 600; n++) begin
      req_valid  = NUM_REQ'($urandom);
      req_data   = {$urandom, $urandom};
      resp_ready = ($urandom_range(3, 0) != 0);
      tick();
    end
    req_valid  = '0;
    resp_ready = 1'b1;
    begin
      int t = 0;
      while (busy && t < 200) begin tick(); t++; end
      check("drain_idle", busy, 0);
    end
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bit_count_arbiter.md
Name: bit_count_arbiter

Overview:
- Round-robin scheduler that shares one asserted-bit-count engine (go/in/out/done interface) among NUM_REQ requesters.
- Accepts one job at a time over per-requester valid/ready and sequences the engine's go pulse and done wait.
- Returns each result tagged with the requester index over a single valid/ready response channel.
- Sits between client blocks and a single engine instance at the top level.

Parameters:
- NUM_REQ, 4, number of requesters (>=2)
- WIDTH, 8, engine input width in bits
- TIMEOUT_CYCLES, 32, max cycles waited for eng_done (used only with the optional feature)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  NUM_REQ  per-requester job valid
- req_data  in  NUM_REQ*WIDTH  packed job data; requester i at bits [i*WIDTH +: WIDTH]
- req_ready  out  NUM_REQ  per-requester accept (one-hot or zero)
- resp_valid  out  1  result available
- resp_ready  in  1  result consumed
- resp_id  out  $clog2(NUM_REQ)  index of the requester that owns the result
- resp_count  out  $clog2(WIDTH+1)  number of asserted bits
- resp_err  out  1  result is a timeout abort
- busy  out  1  high in any state other than IDLE
- eng_go  out  1  engine start pulse
- eng_in  out  WIDTH  engine operand
- eng_out  in  $clog2(WIDTH+1)  engine result
- eng_done  in  1  engine done level

Behaviour:
- Reset (async): state=IDLE, rr pointer=0, all outputs 0, eng_in=0, captured data/id/count=0.
- Engine contract:
  - Engine samples eng_in in the cycle eng_go=1.
  - eng_done drops the cycle after go and rises when the result is ready.
  - eng_out is valid while eng_done=1.
- States:
  - IDLE:
    - If any req_valid is set, grant the first set bit searching from the rr pointer upward, with wrap.
    - req_ready[grant]=1 combinationally, for that single cycle.
    - On grant: capture req_data slice and id, rr pointer <= (grant+1) mod NUM_REQ, go to ISSUE.
    - If no requests: stay in IDLE, req_ready=0.
  - ISSUE: eng_go=1 for exactly one cycle; eng_in=captured data. Go to ARM.
  - ARM: ignore eng_done for one cycle, since a stale high from the previous job is possible. Go to WAIT_DONE.
  - WAIT_DONE:
    - On eng_done=1: register eng_out into resp_count, resp_err=0, go to RESP.
  - RESP:
    - resp_valid=1; resp_id, resp_count and resp_err held stable.
    - On resp_valid & resp_ready: go to IDLE.
    - No grant is issued while in RESP.
- eng_in is driven from the capture register at all times, so it is stable around the go cycle.
- Latency: accept at cycle T, eng_go at T+1, earliest resp_valid at T+4 (eng_done seen at T+3). Exact latency depends on the engine.
- Only req_ready is combinational on req_valid; all other outputs are registered.
- Requester data is sampled only in the accept cycle; later changes have no effect.
- A requester that deasserts req_valid before being granted simply loses its turn.
- Simultaneous requests: exactly one is granted per job. The pointer guarantees every active requester is served within NUM_REQ jobs.
- Pointer wrap: granting requester NUM_REQ-1 sets the pointer to 0.
- Reset asserted mid-job: everything returns to reset values and the in-flight result is discarded. The engine is expected to share rst.

Optional Feature:
- Macro: BIT_COUNT_ARBITER_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on entry to WAIT_DONE.
  - If it reaches TIMEOUT_CYCLES without eng_done, go to RESP with resp_err=1 and resp_count=0.
  - resp_id is the aborted requester; the pointer is already advanced.
- Undefined:
  - No counter; WAIT_DONE waits indefinitely.
  - resp_err is tied 0.
  - TIMEOUT_CYCLES is ignored.

Test Plan:
- Single job, WIDTH=8: req_valid=4'b0001, req_data[7:0]=8'hB5 -> req_ready[0] pulses once; one eng_go pulse with eng_in=8'hB5; resp_valid with resp_id=0, resp_count=5, resp_err=0.
- Contention after reset: req_valid=4'b0101 held -> grant 0 first (resp_id=0), then 2 (resp_id=2), then 0 again; no requester granted twice in a row while another waits.
- Pointer wrap: serve requester 3 with data 8'hFF (count 8), then req_valid=4'b1001 -> next grant is 0.
- Backpressure: resp_ready=0 for 10 cycles with req_valid=4'b1111 -> resp_valid, resp_id and resp_count stable, req_ready=0 throughout, eng_go never pulses; one cycle after resp_ready=1, the next grant occurs.
- Reset mid-job: assert rst during WAIT_DONE -> next cycle all outputs 0, busy=0; after release, req_valid=4'b0010 is granted (pointer back at 0, search finds 1).
- With BIT_COUNT_ARBITER_TIMEOUT_EN, TIMEOUT_CYCLES=32, eng_done tied 0 -> resp_valid with resp_err=1, resp_count=0, 32 cycles after entering WAIT_DONE.
